// File: rtl/butterfly_sched_if.sv
// Scheduler <-> host/memory signal bundle; master is the scheduler side.
// With FFT_ABORT_EN defined the bundle also carries abort/aborted.
interface butterfly_sched_if #(
    parameter int LOG2N = 6
);
    localparam int SW = $clog2(LOG2N);

    logic             start;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [LOG2N-1:0] rd_addr0;
    logic [LOG2N-1:0] rd_addr1;
    logic [LOG2N-2:0] tw_addr;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr0;
    logic [LOG2N-1:0] wr_addr1;
    logic [SW-1:0]    stage;
`ifdef FFT_ABORT_EN
    logic             abort;
    logic             aborted;

    modport master (
        input  start, abort,
        output busy, done, rd_en, rd_addr0, rd_addr1, tw_addr,
               wr_en, wr_addr0, wr_addr1, stage, aborted
    );
    modport slave (
        output start, abort,
        input  busy, done, rd_en, rd_addr0, rd_addr1, tw_addr,
               wr_en, wr_addr0, wr_addr1, stage, aborted
    );
`else
    modport master (
        input  start,
        output busy, done, rd_en, rd_addr0, rd_addr1, tw_addr,
               wr_en, wr_addr0, wr_addr1, stage
    );
    modport slave (
        output start,
        input  busy, done, rd_en, rd_addr0, rd_addr1, tw_addr,
               wr_en, wr_addr0, wr_addr1, stage
    );
`endif
endinterface

// File: rtl/butterfly_sched.sv
// In-place radix-2 FFT butterfly address scheduler; one butterfly per cycle, writes trail reads by
// L=RD_LAT+BF_LAT cycles, stages separated by an L-cycle drain. Optional abort under FFT_ABORT_EN.
module butterfly_sched #(
    parameter int LOG2N  = 6,
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    butterfly_sched_if.master bus
);
    localparam int N    = 1 << LOG2N;
    localparam int HALF = N / 2;
    localparam int L    = RD_LAT + BF_LAT;
    localparam int KW   = LOG2N - 1;
    localparam int SW   = $clog2(LOG2N);
    localparam int CW   = (L > 1) ? $clog2(L) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             rd_en_q, busy_q, done_q;
    logic [LOG2N-1:0] rd_addr0_q, rd_addr1_q;
    logic [LOG2N-2:0] tw_addr_q;

    logic             pen_q [L];
    logic [LOG2N-1:0] pa0_q [L];
    logic [LOG2N-1:0] pa1_q [L];

    logic             issue;
    logic             drain_abort;

    logic [LOG2N-1:0] span, pos, grp, a0_d, a1_d;
    logic [LOG2N-2:0] tw_d;

`ifdef FFT_ABORT_EN
    logic pend_q, pend_d;
    logic aborted_q, aborted_d;

    // Abort suppresses the read in the very cycle it is raised.
    assign issue       = rd_en_q & ~bus.abort;
    assign drain_abort = pend_q | bus.abort;
    assign bus.aborted = aborted_q;
`else
    assign issue       = rd_en_q;
    assign drain_abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
`ifdef FFT_ABORT_EN
        pend_d    = pend_q;
        aborted_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    k_d     = '0;
                    stage_d = '0;
`ifdef FFT_ABORT_EN
                    pend_d  = 1'b0;
`endif
                end
            end
            RUN: begin
`ifdef FFT_ABORT_EN
                // The aborted cycle already counts as one drain cycle.
                if (bus.abort) begin
                    if (L == 1) begin
                        state_d   = IDLE;
                        aborted_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        cnt_d   = CW'((L > 1) ? L - 2 : 0);
                        pend_d  = 1'b1;
                    end
                end else
`endif
                if (k_q == KW'(HALF - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = CW'(L - 1);
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DRAIN: begin
`ifdef FFT_ABORT_EN
                pend_d = drain_abort;
`endif
                if (cnt_q == '0) begin
                    if (drain_abort) begin
                        state_d = IDLE;
`ifdef FFT_ABORT_EN
                        aborted_d = 1'b1;
`endif
                    end else if (stage_q == SW'(LOG2N - 1)) begin
                        state_d = FIN;
                    end else begin
                        state_d = RUN;
                        stage_d = stage_q + SW'(1);
                        k_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Butterfly k of stage s pairs elements grp*2*span+pos and that plus span.
    always_comb begin
        span = LOG2N'(1) << stage_d;
        pos  = {1'b0, k_d} & (span - LOG2N'(1));
        grp  = {1'b0, k_d} >> stage_d;
        a0_d = (grp << (int'(stage_d) + 1)) | pos;
        a1_d = a0_d | span;
        tw_d = pos[LOG2N-2:0] << (LOG2N - 1 - int'(stage_d));
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            stage_q    <= '0;
            cnt_q      <= '0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_addr0_q <= '0;
            rd_addr1_q <= '0;
            tw_addr_q  <= '0;
            for (int i = 0; i < L; i++) begin
                pen_q[i] <= 1'b0;
                pa0_q[i] <= '0;
                pa1_q[i] <= '0;
            end
`ifdef FFT_ABORT_EN
            pend_q    <= 1'b0;
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            stage_q    <= stage_d;
            cnt_q      <= cnt_d;
            rd_en_q    <= (state_d == RUN);
            busy_q     <= (state_d == RUN) || (state_d == DRAIN);
            done_q     <= (state_d == FIN);
            rd_addr0_q <= (state_d == RUN) ? a0_d : '0;
            rd_addr1_q <= (state_d == RUN) ? a1_d : '0;
            tw_addr_q  <= (state_d == RUN) ? tw_d : '0;
            pen_q[0]   <= issue;
            pa0_q[0]   <= rd_addr0_q;
            pa1_q[0]   <= rd_addr1_q;
            for (int i = L - 1; i > 0; i--) begin
                pen_q[i] <= pen_q[i-1];
                pa0_q[i] <= pa0_q[i-1];
                pa1_q[i] <= pa1_q[i-1];
            end
`ifdef FFT_ABORT_EN
            pend_q    <= pend_d;
            aborted_q <= aborted_d;
`endif
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd_en    = issue;
    assign bus.rd_addr0 = rd_addr0_q;
    assign bus.rd_addr1 = rd_addr1_q;
    assign bus.tw_addr  = tw_addr_q;
    assign bus.wr_en    = pen_q[L-1];
    assign bus.wr_addr0 = pa0_q[L-1];
    assign bus.wr_addr1 = pa1_q[L-1];
    assign bus.stage    = stage_q;
endmodule

// File: tb/tb_butterfly_sched.sv
// Bench for butterfly_sched: closed-form schedule model, random start noise and reset points.
module tb_butterfly_sched;
    localparam int LOG2N  = 6;
    localparam int RD_LAT = 1;
    localparam int BF_LAT = 1;
    localparam int L      = RD_LAT + BF_LAT;
    localparam int HALF   = (1 << LOG2N) / 2;
    localparam int P      = HALF + L;
    localparam int TOTAL  = LOG2N * P;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    butterfly_sched_if #(.LOG2N(LOG2N)) bus ();

    butterfly_sched #(.LOG2N(LOG2N), .RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       rd_en;
        logic [5:0] a0;
        logic [5:0] a1;
        logic [4:0] tw;
        logic [2:0] stage;
        logic       wr_en;
        logic [5:0] w0;
        logic [5:0] w1;
        logic       busy;
        logic       done;
    } snap_t;

    // Read side of relative cycle c, where start was sampled in cycle 0.
    function automatic snap_t rd_part(input int c);
        snap_t r = '0;
        int st, k, span, base;
        if (c >= 1 && c <= TOTAL) begin
            st = (c - 1) / P;
            k  = (c - 1) % P;
            if (k < HALF) begin
                span    = 1 << st;
                base    = (k / span) * 2 * span + (k % span);
                r.rd_en = 1'b1;
                r.a0    = 6'(base);
                r.a1    = 6'(base + span);
                r.tw    = 5'((k % span) * (1 << (LOG2N - 1 - st)));
                r.stage = 3'(st);
            end
        end
        return r;
    endfunction

    function automatic snap_t expect_at(input int c);
        snap_t e, w;
        e      = rd_part(c);
        w      = rd_part(c - L);
        e.wr_en = w.rd_en;
        e.w0    = w.a0;
        e.w1    = w.a1;
        e.busy  = (c >= 1 && c <= TOTAL);
        e.done  = (c == TOTAL + 1);
        return e;
    endfunction

    function automatic snap_t sample(input logic keep_rd, input logic keep_wr);
        snap_t o;
        o.rd_en = bus.rd_en;
        o.a0    = keep_rd ? bus.rd_addr0 : '0;
        o.a1    = keep_rd ? bus.rd_addr1 : '0;
        o.tw    = keep_rd ? bus.tw_addr  : '0;
        o.stage = keep_rd ? bus.stage    : '0;
        o.wr_en = bus.wr_en;
        o.w0    = keep_wr ? bus.wr_addr0 : '0;
        o.w1    = keep_wr ? bus.wr_addr1 : '0;
        o.busy  = bus.busy;
        o.done  = bus.done;
        return o;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        snap_t o;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        repeat (3) tick();
        @(negedge clock);
        o = sample(1'b1, 1'b1);
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", o);
        end
`ifdef FFT_ABORT_EN
        checks++;
        if (bus.aborted !== 1'b0) begin
            errors++;
            $display("FAIL reset_aborted got=%b exp=0", bus.aborted);
        end
`endif
        tick();
        reset_n = 1'b1;
        @(negedge clock);
        o = sample(1'b1, 1'b1);
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL idle_after_reset got=%h exp=0", o);
        end
    endtask

    task automatic test_full_pass(input bit noisy, input string tag);
        snap_t e, o;
        int rd_cnt = 0;
        int wr_cnt = 0;
        tick();
        bus.start = 1'b1;
        for (int c = 0; c <= TOTAL + 1; c++) begin
            @(negedge clock);
            e = expect_at(c);
            o = sample(e.rd_en, e.wr_en);
            rd_cnt += int'(bus.rd_en);
            wr_cnt += int'(bus.wr_en);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s cycle=%0d got=%h exp=%h", tag, c, o, e);
            end
            if (c == 6) begin
                checks++;
                if ({bus.rd_addr0, bus.rd_addr1, bus.tw_addr} !== {6'd10, 6'd11, 5'd0}) begin
                    errors++;
                    $display("FAIL addr_s0_k5 got=%0d/%0d/%0d exp=10/11/0",
                             bus.rd_addr0, bus.rd_addr1, bus.tw_addr);
                end
            end
            if (c == 1 + 3 * P + 13) begin
                checks++;
                if ({bus.rd_addr0, bus.rd_addr1, bus.tw_addr} !== {6'd21, 6'd29, 5'd20}) begin
                    errors++;
                    $display("FAIL addr_s3_k13 got=%0d/%0d/%0d exp=21/29/20",
                             bus.rd_addr0, bus.rd_addr1, bus.tw_addr);
                end
            end
            tick();
            bus.start = (noisy && c + 1 <= TOTAL + 1) ? 1'($urandom % 2) : 1'b0;
        end
        checks++;
        if (rd_cnt != LOG2N * HALF || wr_cnt != LOG2N * HALF) begin
            errors++;
            $display("FAIL %s_counts got rd=%0d wr=%0d exp=%0d each", tag, rd_cnt, wr_cnt, LOG2N * HALF);
        end
    endtask

    task automatic test_single_pass();
        test_full_pass(1'b0, "pass");
    endtask

    task automatic test_start_ignored();
        test_full_pass(1'b1, "noisy_pass");
    endtask

    task automatic test_reset_mid(input int at);
        snap_t e, o;
        tick();
        bus.start = 1'b1;
        for (int c = 0; c <= at; c++) begin
            @(negedge clock);
            e = expect_at(c);
            o = sample(e.rd_en, e.wr_en);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL mid_pre cycle=%0d got=%h exp=%h", c, o, e);
            end
            tick();
            bus.start = 1'b0;
            reset_n   = (c + 1 == at) ? 1'b0 : 1'b1;
        end
        @(negedge clock);
        o = sample(1'b1, 1'b1);
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL reset_mid_zero at=%0d got=%h exp=0", at, o);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge clock);
            checks++;
            if ({bus.rd_en, bus.wr_en, bus.busy, bus.done} !== 4'b0) begin
                errors++;
                $display("FAIL no_activity_after_reset i=%0d got=%b exp=0000", i,
                         {bus.rd_en, bus.wr_en, bus.busy, bus.done});
            end
        end
        test_full_pass(1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        snap_t e, o;
        int rel;
        tick();
        bus.start = 1'b1;
        for (int c = 0; c < 2 * (TOTAL + 2); c++) begin
            @(negedge clock);
            rel = (c <= TOTAL + 1) ? c : c - (TOTAL + 2);
            e = expect_at(rel);
            o = sample(e.rd_en, e.wr_en);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL back_to_back cycle=%0d got=%h exp=%h", c, o, e);
            end
            tick();
            bus.start = (c + 1 < 2 * (TOTAL + 2)) ? 1'b1 : 1'b0;
        end
    endtask

`ifdef FFT_ABORT_EN
    task automatic test_abort(input int a);
        snap_t e, o;
        tick();
        bus.start = 1'b1;
        for (int c = 0; c <= a + 5; c++) begin
            @(negedge clock);
            e = expect_at(c);
            if (c >= a) begin
                e.rd_en = 1'b0; e.a0 = '0; e.a1 = '0; e.tw = '0; e.stage = '0;
            end
            if (c - L >= a) begin
                e.wr_en = 1'b0; e.w0 = '0; e.w1 = '0;
            end
            e.busy = (c >= 1 && c <= a + 1);
            e.done = 1'b0;
            o = sample(e.rd_en, e.wr_en);
            checks++;
            if (o !== e || bus.aborted !== (c == a + 2)) begin
                errors++;
                $display("FAIL abort a=%0d cycle=%0d got=%h/%b exp=%h/%b", a, c, o, bus.aborted,
                         e, (c == a + 2));
            end
            tick();
            bus.start = 1'b0;
            bus.abort = (c + 1 == a);
        end
    endtask
`endif

    initial begin
        bus.start = 1'b0;
`ifdef FFT_ABORT_EN
        bus.abort = 1'b0;
`endif
        test_reset();
        test_single_pass();
        test_start_ignored();
        test_reset_mid(50);
        test_reset_mid(int'($urandom_range(2, TOTAL - 1)));
        test_back_to_back();
`ifdef FFT_ABORT_EN
        test_abort(10);
        test_abort(int'($urandom_range(1, HALF)));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/butterfly_sched.md
BUTTERFLY_SCHED -- requirements
Module: butterfly_sched

Interface
REQ-001 SHALL have parameter LOG2N, default 6, meaning log2 of FFT size N (N=64).
REQ-002 SHALL have parameter RD_LAT, default 1, meaning data-memory read latency in cycles.
REQ-003 SHALL have parameter BF_LAT, default 1, meaning twiddle-multiply plus butterfly pipeline latency in cycles; L = RD_LAT+BF_LAT.
REQ-004 SHALL have port clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  request one full in-place FFT pass.
REQ-007 SHALL have port busy  output  1  high while issuing or draining.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports rd_en  output  1; rd_addr0, rd_addr1  output  LOG2N  butterfly operand read addresses.
REQ-010 SHALL have port tw_addr  output  LOG2N-1  twiddle ROM index, aligned with rd_en.
REQ-011 SHALL have ports wr_en  output  1; wr_addr0, wr_addr1  output  LOG2N  result write-back addresses.
REQ-012 SHALL have port stage  output  $clog2(LOG2N)  current issuing stage.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN, FIN.
REQ-014 IDLE: start=1 SHALL move to RUN with stage=0, k=0; start ignored in all other states.
REQ-015 RUN: each cycle SHALL assert rd_en and issue butterfly k (0..N/2-1) of current stage s, then increment k.
REQ-016 Addresses SHALL be: span=2^s, pos=k mod span, grp=k>>s, rd_addr0=grp*2*span+pos, rd_addr1=rd_addr0+span, tw_addr=pos<<(LOG2N-1-s); all unsigned, no overflow possible.
REQ-017 After issuing k=N/2-1, SHALL go to DRAIN; rd_en low in DRAIN.
REQ-018 wr_en, wr_addr0, wr_addr1 SHALL equal rd_en, rd_addr0, rd_addr1 delayed exactly L cycles via a shift pipeline.
REQ-019 DRAIN SHALL last until the last write of the stage is issued (L cycles); next stage's first read SHALL occur the cycle after that write (read-after-write safe).
REQ-020 From DRAIN: if s<LOG2N-1, SHALL increment stage, clear k, return to RUN; else go to FIN.
REQ-021 FIN SHALL last one cycle with done=1, busy=0, then IDLE.
REQ-022 With start sampled in cycle 0: stage s reads in cycles 1+s(N/2+L) .. s(N/2+L)+N/2; done in cycle LOG2N(N/2+L)+1.
REQ-023 busy SHALL be 1 exactly in RUN and DRAIN.
REQ-024 start asserted in the same cycle as done SHALL be ignored; start held high in IDLE SHALL begin a new pass.

Reset
REQ-025 reset_n=0 at a clock edge SHALL force IDLE, clear k, stage and delay pipeline; busy, done, rd_en, wr_en, all addresses, tw_addr, stage SHALL read 0.
REQ-026 Reset mid-operation SHALL abandon the pass immediately; no wr_en SHALL follow reset release.

Configuration
REQ-027 Macro FFT_ABORT_EN defined: SHALL add input abort (1 bit) and output aborted (1 bit).
REQ-028 With FFT_ABORT_EN: abort=1 in RUN SHALL stop issue that cycle (rd_en=0), drain in-flight writes (wr_en continues L cycles), then IDLE with one-cycle aborted pulse and no done; abort in DRAIN SHALL finish draining then abort; abort in IDLE/FIN ignored.
REQ-029 Without FFT_ABORT_EN: no abort/aborted ports; behaviour per REQ-013..026 only.

Verification
REQ-030 LOG2N=6, L=2: start pulse cycle 0 -> 192 rd_en cycles, 192 wr_en cycles, done only in cycle 205, busy high cycles 1..204.
REQ-031 Stage 0, k=5 -> rd_addr0=10, rd_addr1=11, tw_addr=0; stage 3, k=13 -> rd_addr0=21, rd_addr1=29, tw_addr=20.
REQ-032 Every cycle -> wr_addr0/1 equal rd_addr0/1 from 2 cycles earlier; stage 1 first read (cycle 35) follows stage 0 last write (cycle 34).
REQ-033 reset_n=0 at cycle 50 for one cycle -> all outputs 0 from cycle 51, no wr_en afterwards, new start runs full 205-cycle pass.
REQ-034 start held high continuously -> back-to-back passes, second pass first rd_en one cycle after IDLE re-entry; start during busy ignored.
REQ-035 FFT_ABORT_EN, abort at cycle 10 -> rd_en low from cycle 10, wr_en through cycle 11, aborted pulse cycle 12, done never asserted.
